// File: rtl/fifo_wr_arbiter.sv
// Purpose: round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Latency: grant taken on the edge valid is seen in ARB; first word written on the next edge, 1 word/cycle after.
// Backpressure: full gates wr_en/req_ready in the same cycle; the grant is held (beat frozen) while full.
//
// Ports:
//   wr_clk, wr_rst_n  write-domain clock, asynchronous active-low reset
//   req_valid/_data   per-producer word offer; producer i owns req_data[i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready         per-producer accept, one-hot or zero
//   wr_en, wr_data    FIFO write pins
//   full              FIFO full flag
//   grant_id          current (or most recent) granted producer
//   busy              high while a grant is held
//   word_cnt          total words written since reset, wraps at 2^16
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          full,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic [15:0]                   word_cnt
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [BW-1:0]  BEAT_LAST = BW'(MAX_BURST - 1);
  localparam logic [IDW-1:0] ID_MAX    = IDW'(NUM_REQ - 1);

  typedef enum logic {
    ST_ARB,
    ST_GRANT
  } state_t;

  state_t         state;
  logic [IDW-1:0] last;
  logic [BW-1:0]  beat;
  logic [IDW-1:0] rr_sel;
  logic           cur_vld;
  logic           accept;

  // First valid producer scanning upward from prev+1, wrapping at NUM_REQ.
  // Only consulted when at least one request is valid.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                             input logic [IDW-1:0]     prev);
    logic [IDW-1:0] sel;
    logic [IDW-1:0] idx;
    logic           found;
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(prev) + k) % NUM_REQ);
      if (!found && vld[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign rr_sel  = rr_pick(req_valid, last);
  assign busy    = (state == ST_GRANT);
  assign cur_vld = req_valid[grant_id];
  assign accept  = busy & cur_vld & ~full;
  assign wr_en   = accept;
  assign wr_data = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];

  // Ready does not depend on valid: the granted producer sees ready whenever
  // the FIFO has room, so a word is taken exactly when it is offered.
  always_comb begin
    req_ready = '0;
    if (busy && !full) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state    <= ST_ARB;
      grant_id <= '0;
      last     <= ID_MAX;
      beat     <= '0;
      word_cnt <= '0;
    end else begin
      if (accept) begin
        word_cnt <= word_cnt + 16'd1;
      end
      case (state)
        ST_ARB: begin
          if (|req_valid) begin
            grant_id <= rr_sel;
            beat     <= '0;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // A full-length accept ends the burst regardless of what valid does
          // afterwards; a valid drop without accept forfeits the grant.
          if (accept) begin
            beat <= beat + BW'(1);
            if (beat == BEAT_LAST) begin
              last  <= grant_id;
              state <= ST_ARB;
            end
          end else if (!cur_vld) begin
            last  <= grant_id;
            state <= ST_ARB;
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized producers,
// a behavioural FIFO (depth 16, drained every other cycle) and per-producer
// sequence checking of everything that comes out of the FIFO.
module tb_fifo_wr_arbiter;

  localparam int DW    = 8;
  localparam int NR    = 4;
  localparam int MB    = 4;
  localparam int DEPTH = 16;

  logic             wr_clk = 1'b0;
  logic             wr_rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             wr_en;
  logic [DW-1:0]    wr_data;
  logic             full;
  logic [1:0]       grant_id;
  logic             busy;
  logic [15:0]      word_cnt;

  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .wr_clk    (wr_clk),
    .wr_rst_n  (wr_rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .grant_id  (grant_id),
    .busy      (busy),
    .word_cnt  (word_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Producer agents: pend words left to send, seq = next sequence number.
  int pend[NR];
  int seq[NR];
  int acc_cnt[NR];
  bit hold[NR];
  int force_full;

  // FIFO model and output scoreboard.
  logic [DW-1:0] fifo_q[$];
  int exp_seq[NR];
  int pop_cnt[NR];
  int cyc;

  // Reference model: owner of the running burst (-1 = none), words in it,
  // most recent owner, displayed grant id, expected word counter.
  int m_cur, m_nb, m_last, m_gid, m_cnt;

  logic [63:0] trace;
  int tcyc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_first(input logic [NR-1:0] v, input int prev);
    for (int k = 1; k <= NR; k++) begin
      if (v[(prev + k) % NR]) return (prev + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] word_of(input int p, input int s);
    return DW'((p << 6) | (s & 63));
  endfunction

  task automatic model_reset();
    m_cur  = -1;
    m_nb   = 0;
    m_last = NR - 1;
    m_gid  = 0;
    m_cnt  = 0;
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < NR; p++) begin
      req_valid[p]           = (pend[p] > 0) && !hold[p];
      req_data[p*DW +: DW]   = word_of(p, seq[p]);
    end
    full = (fifo_q.size() >= DEPTH) || (force_full > 0);
  endtask

  // One clock cycle: compare at negedge, advance model, then update agents,
  // FIFO model and inputs just after the posedge.
  task automatic step();
    logic [NR-1:0] acc;
    logic [NR-1:0] exp_rdy;
    logic          exp_we;
    logic          w;
    logic [DW-1:0] wd;
    logic [DW-1:0] d;
    int            s;
    int            p;
    @(negedge wr_clk);
    exp_we  = 1'b0;
    exp_rdy = '0;
    if (m_cur >= 0) begin
      exp_we = req_valid[m_cur] && !full;
      if (!full) exp_rdy[m_cur] = 1'b1;
    end
    check_eq("busy", busy, (m_cur >= 0));
    check_eq("grant_id", grant_id, m_gid);
    check_eq("wr_en", wr_en, exp_we);
    check_eq("req_ready", req_ready, exp_rdy);
    check_eq("word_cnt", word_cnt, m_cnt);
    check_eq("write_while_full", wr_en & full, 1'b0);
    if (exp_we) check_eq("wr_data", wr_data, word_of(m_cur, seq[m_cur]));
    acc = req_valid & req_ready;
    w   = wr_en;
    wd  = wr_data;
    if (tcyc < 64) begin
      trace[tcyc] = w;
      tcyc++;
    end
    if (wr_rst_n) begin
      if (m_cur < 0) begin
        s = rr_first(req_valid, m_last);
        if (s >= 0) begin
          m_cur = s;
          m_gid = s;
          m_nb  = 0;
        end
      end else if (exp_we) begin
        m_nb++;
        m_cnt = (m_cnt + 1) % 65536;
        if (m_nb == MB) begin
          m_last = m_cur;
          m_cur  = -1;
        end
      end else if (!req_valid[m_cur]) begin
        m_last = m_cur;
        m_cur  = -1;
      end
    end
    @(posedge wr_clk);
    #1;
    cyc++;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        seq[i]++;
        pend[i]--;
        acc_cnt[i]++;
      end
    end
    if (w) fifo_q.push_back(wd);
    if ((cyc % 2 == 0) && (fifo_q.size() > 0)) begin
      d = fifo_q.pop_front();
      p = int'(d[7:6]);
      check_eq("fifo_order", d[5:0], exp_seq[p] & 63);
      exp_seq[p]++;
      pop_cnt[p]++;
    end
    if (force_full > 0) force_full--;
    drive_inputs();
  endtask

  task automatic do_reset();
    wr_rst_n = 1'b0;
    #1;
    check_eq("rst_wr_en", wr_en, 1'b0);
    check_eq("rst_ready", req_ready, '0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_grant", grant_id, 2'd0);
    check_eq("rst_word_cnt", word_cnt, 16'd0);
    model_reset();
    step();
    step();
    wr_rst_n = 1'b1;
  endtask

  initial begin : main
    int base[NR];
    int i;
    bit done;
    for (int p = 0; p < NR; p++) begin
      pend[p] = 0; seq[p] = 0; acc_cnt[p] = 0; hold[p] = 0;
      exp_seq[p] = 0; pop_cnt[p] = 0;
    end
    force_full = 0;
    cyc = 0;
    tcyc = 0;
    trace = '0;
    wr_rst_n = 1'b0;
    model_reset();
    drive_inputs();
    #3;
    check_eq("init_wr_en", wr_en, 1'b0);
    check_eq("init_ready", req_ready, '0);
    check_eq("init_busy", busy, 1'b0);
    check_eq("init_grant", grant_id, 2'd0);
    check_eq("init_word_cnt", word_cnt, 16'd0);
    step();
    step();
    wr_rst_n = 1'b1;

    // Only producer 2, six words: 4 writes, bubble, 2 writes.
    pend[2] = 6;
    drive_inputs();
    tcyc = 0;
    for (int k = 0; k < 10; k++) step();
    check_eq("t1_trace", trace[9:0], 10'h0DE);
    check_eq("t1_word_cnt", word_cnt, 16'd6);
    check_eq("t1_grant", grant_id, 2'd2);

    // All four producers continuously valid: 8 words each.
    do_reset();
    for (int p = 0; p < NR; p++) begin
      base[p] = acc_cnt[p];
      pend[p] = 8;
    end
    drive_inputs();
    for (int k = 0; k < 60; k++) step();
    for (int p = 0; p < NR; p++) check_eq($sformatf("t2_words_p%0d", p), acc_cnt[p] - base[p], 8);

    // Producer 1 burst with full forced high for 5 cycles after 2 words.
    base[1] = acc_cnt[1];
    pend[1] = 4;
    drive_inputs();
    i = 0;
    while (i < 20 && acc_cnt[1] - base[1] < 2) begin
      step();
      i++;
    end
    check_eq("t3_reach_beat2", acc_cnt[1] - base[1], 2);
    force_full = 5;
    drive_inputs();
    for (int k = 0; k < 5; k++) step();
    check_eq("t3_held_words", acc_cnt[1] - base[1], 2);
    check_eq("t3_held_grant", grant_id, 2'd1);
    check_eq("t3_held_busy", busy, 1'b1);
    for (int k = 0; k < 10; k++) step();
    check_eq("t3_done_words", acc_cnt[1] - base[1], 4);

    // Producer 3 drops after 2 words while producer 0 waits.
    base[3] = acc_cnt[3];
    base[0] = acc_cnt[0];
    pend[3] = 2;
    drive_inputs();
    step();
    pend[0] = 3;
    drive_inputs();
    for (int k = 0; k < 14; k++) step();
    check_eq("t4_p3_words", acc_cnt[3] - base[3], 2);
    check_eq("t4_p0_words", acc_cnt[0] - base[0], 3);
    check_eq("t4_grant_hold", grant_id, 2'd0);

    // Reset during the third beat of a producer 2 burst.
    base[2] = acc_cnt[2];
    pend[2] = 6;
    drive_inputs();
    i = 0;
    while (i < 20 && acc_cnt[2] - base[2] < 2) begin
      step();
      i++;
    end
    #1;
    check_eq("t5_beat3_wr_en", wr_en, 1'b1);
    pend[0] = 1;
    drive_inputs();
    do_reset();
    step();
    check_eq("t5_prio_grant", grant_id, 2'd0);
    for (int k = 0; k < 15; k++) step();
    check_eq("t5_word_cnt", word_cnt, 16'd5);

    // Random producers against the depth-16 FIFO drained at half rate.
    for (int k = 0; k < 3000; k++) begin
      for (int p = 0; p < NR; p++) begin
        if (pend[p] == 0 && ($urandom % 4) == 0) pend[p] = $urandom_range(1, 12);
        hold[p] = (($urandom % 4) == 0);
      end
      drive_inputs();
      step();
    end
    for (int p = 0; p < NR; p++) begin
      pend[p] = 0;
      hold[p] = 0;
    end
    drive_inputs();
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      step();
      done = (fifo_q.size() == 0) && !busy;
    end
    check_eq("drain_done", done, 1'b1);
    for (int p = 0; p < NR; p++) check_eq($sformatf("t6_count_p%0d", p), pop_cnt[p], acc_cnt[p]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin burst arbiter sharing the write port of one `async_fifo` among `NUM_REQ` producers in the write clock domain. Each producer offers words via a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to `MAX_BURST` words and gates every write on `full`. It sits directly in front of the FIFO's `wr_en`/`wr_data`/`full` pins; the read side is untouched.

## Interface
- `DATA_WIDTH`, 8, word width; matches the FIFO.
- `NUM_REQ`, 4, number of producers (≥2).
- `MAX_BURST`, 4, maximum words per grant (≥1).
- `wr_clk`  in  1  write-domain clock; all state on posedge.
- `wr_rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-producer word valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH  packed words; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  per-producer accept (one-hot or zero).
- `wr_en`  out  1  to FIFO `wr_en`.
- `wr_data`  out  DATA_WIDTH  to FIFO `wr_data`.
- `full`  in  1  from FIFO `full`.
- `grant_id`  out  $clog2(NUM_REQ)  current/last granted producer.
- `busy`  out  1  high while in GRANT state.
- `word_cnt`  out  16  total words written since reset; wraps at 2^16.

## Operation
- FSM has two states:
  - **ARB**: no grant held.
    - If any `req_valid` is high, select the first valid producer scanning upward from `last+1` (mod NUM_REQ).
    - Load `grant_id`, clear `beat`, and go to GRANT.
    - If no `req_valid` is high, stay in ARB.
  - **GRANT**: burst in progress.
    - Accept is defined as `req_valid[grant_id] & !full`.
    - On accept: `beat` increments. If `beat == MAX_BURST-1`, set `last = grant_id` and go to ARB.
    - If `req_valid[grant_id]` is low, set `last = grant_id` and go to ARB; the burst ends early.
    - If `full` is high while valid: stay in GRANT with `beat` unchanged. The grant is held while the FIFO is full.
- Outputs are combinational from registered state:
  - `wr_en = busy & req_valid[grant_id] & !full`.
  - `req_ready[i] = busy & (i == grant_id) & !full`.
  - `wr_data = req_data[grant_id]` (don't-care when `wr_en` is low).
- Producers must hold `req_valid` and data stable until accepted. Deasserting valid without being accepted forfeits the grant; no data is written.
- `word_cnt` increments by 1 on every cycle where `wr_en` is high.
- A requester newly asserting valid mid-burst does not pre-empt the current grant.

## Timing
- Reset (asynchronous, immediate) values:
  - State ARB, `busy` 0, `grant_id` 0, `beat` 0, `word_cnt` 0.
  - `last` is NUM_REQ-1, so producer 0 wins the first arbitration.
  - `wr_en` 0 and `req_ready` all 0.
- Arbitration latency: valid seen in ARB at edge N → GRANT from edge N. The first word can be written at edge N+1.
- Every burst has exactly one ARB bubble cycle after it ends, including back-to-back bursts by the same producer.
- Burst throughput is 1 word/cycle while `full` is low.
- `full` gating is zero-latency:
  - A cycle with `full` high never asserts `wr_en`.
  - The FIFO's own full update after the last free slot is written is honoured on the next cycle.
- Simultaneous burst-end events:
  - Accept of beat MAX_BURST-1 ends the burst on that edge.
  - Valid-drop in the same cycle is irrelevant, because the accept already ended the burst.
- Reset asserted mid-burst: ready and `wr_en` drop immediately. Words accepted on earlier edges remain in the FIFO. There is no partial-word hazard because each write is a single edge.
- `grant_id` holds its value through ARB until the next grant.
- `word_cnt` 16'hFFFF plus one write → 16'h0000.

## Test plan
- Reset, then only producer 2 valid with 6 words, `MAX_BURST`=4, `full`=0 → 4 writes, 1 bubble, 2 writes.
  - `grant_id`=2 throughout; `word_cnt`=6; FIFO contents are in order.
- All 4 producers continuously valid → grant order 0,1,2,3,0…
  - 4 words each per burst, one ARB cycle between bursts.
  - After 32 writes, each producer has 8 words accepted.
- Producer 1 granted, `full` forced high for 5 cycles mid-burst → `wr_en`/`req_ready` low for those 5 cycles.
  - `grant_id` stays 1; `beat` is preserved.
  - The burst resumes and completes its remaining words.
- Producer 3 drops valid after 2 words while producer 0 is waiting → burst ends.
  - ARB grants 0 (scan 0 after last=3); only 2 words from producer 3 are written.
- Assert `wr_rst_n` low during the 3rd beat of a burst → outputs are reset values within the same cycle.
  - After release, producer 0 has priority; `word_cnt`=0.
- Drive the async FIFO (DEPTH 16) through the arbiter with random valid patterns from 4 producers, with the read side draining at half rate.
  - Per-producer word order is preserved, with no loss or duplication.
  - No write ever occurs with `full` high.
